// File: rtl/bp_fe_fetch_buffer.sv
// rtl/bp_fe_fetch_buffer.sv - multi-instruction fetch packet buffer feeding the FE queue
// Stores whole fetch packets and drains them one instruction (or exception item) per cycle.
module bp_fe_fetch_buffer
  #(parameter int els_p         = 4
  , parameter int fetch_insns_p = 2
  , parameter int instr_width_p = 32
  , parameter int vaddr_width_p = 39
  , parameter int meta_width_p  = 64
  , localparam int cnt_width_lp = $clog2(fetch_insns_p+1)
  )
  (input  logic                                   clk_i
  , input  logic                                  reset_i
  , input  logic                                  flush_i
  , input  logic                                  fetch_v_i
  , output logic                                  fetch_ready_and_o
  , input  logic [vaddr_width_p-1:0]              fetch_pc_i
  , input  logic [fetch_insns_p*instr_width_p-1:0] fetch_instr_i
  , input  logic [cnt_width_lp-1:0]               fetch_count_i
  , input  logic [1:0]                            fetch_exc_i
  , input  logic [meta_width_p-1:0]               fetch_meta_i
  , output logic                                  fe_v_o
  , input  logic                                  fe_ready_and_i
  , output logic [vaddr_width_p-1:0]              fe_pc_o
  , output logic [instr_width_p-1:0]              fe_instr_o
  , output logic [1:0]                            fe_exc_o
  , output logic [meta_width_p-1:0]               fe_meta_o
  , output logic                                  fe_last_o
  , output logic [$clog2(els_p+1)-1:0]            count_o
  );

  localparam int ptr_width_lp = $clog2(els_p);
  localparam logic [cnt_width_lp-1:0] max_count_lp = cnt_width_lp'(fetch_insns_p);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  logic [ptr_width_lp:0]   head_r, tail_r;
  logic [ptr_width_lp-1:0] head_idx, tail_idx;
  logic [cnt_width_lp-1:0] idx_r;

  logic [vaddr_width_p-1:0]                      pc_r    [els_p];
  logic [fetch_insns_p-1:0][instr_width_p-1:0]   instr_r [els_p];
  logic [cnt_width_lp-1:0]                       cnt_r   [els_p];
  logic [1:0]                                    exc_r   [els_p];
  logic [meta_width_p-1:0]                       meta_r  [els_p];

  logic full, empty, enq, store, deq, last;
  logic [1:0]              head_exc;
  logic [cnt_width_lp-1:0] head_cnt;

  assign head_idx = head_r[ptr_width_lp-1:0];
  assign tail_idx = tail_r[ptr_width_lp-1:0];
  assign empty    = (head_r == tail_r);
  assign full     = (head_idx == tail_idx) && (head_r[ptr_width_lp] != tail_r[ptr_width_lp]);

  assign fetch_ready_and_o = ~full;
  assign enq   = fetch_v_i & ~full;
  // Empty non-exception packets are acknowledged but never occupy an entry
  assign store = enq & ~flush_i & ((fetch_exc_i != 2'b00) | (fetch_count_i != '0));

  assign fe_v_o   = ~empty;
  assign deq      = fe_v_o & fe_ready_and_i;
  assign head_exc = exc_r[head_idx];
  assign head_cnt = cnt_r[head_idx];
  assign last     = (head_exc != 2'b00) | ((idx_r + cnt_width_lp'(1)) == head_cnt);
  assign count_o  = tail_r - head_r;

  always_comb begin
    fe_pc_o    = '0;
    fe_instr_o = '0;
    fe_exc_o   = '0;
    fe_meta_o  = '0;
    fe_last_o  = 1'b0;
    if (fe_v_o) begin
      fe_meta_o = meta_r[head_idx];
      fe_last_o = last;
      fe_exc_o  = head_exc;
      if (head_exc != 2'b00) begin
        fe_pc_o = pc_r[head_idx];
      end else begin
        fe_pc_o = pc_r[head_idx] + vaddr_width_p'({idx_r, 2'b00});
        for (int s = 0; s < fetch_insns_p; s++) begin
          if (idx_r == cnt_width_lp'(s)) fe_instr_o = instr_r[head_idx][s];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      head_r <= '0;
      tail_r <= '0;
      idx_r  <= '0;
    end else begin
      if (store) tail_r <= tail_r + 1'b1;
      if (deq) begin
        if (last) begin
          idx_r  <= '0;
          head_r <= head_r + 1'b1;
        end else begin
          idx_r <= idx_r + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      pc_r[tail_idx]    <= fetch_pc_i;
      instr_r[tail_idx] <= fetch_instr_i;
      cnt_r[tail_idx]   <= fetch_count_i;
      exc_r[tail_idx]   <= fetch_exc_i;
      meta_r[tail_idx]  <= fetch_meta_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && fetch_v_i) assert (fetch_count_i <= max_count_lp);
  end

endmodule

// File: doc/bp_fe_fetch_buffer.md
Name: bp_fe_fetch_buffer

Overview:
- Parametrised multi-instruction fetch buffer between fetch pipeline and FE queue, for next-gen FE with fetch width >1.
- Accepts one fetch packet per cycle: up to fetch_insns_p instructions, common base PC, exception code, branch metadata.
- Holds up to els_p packets; drains one instruction (or one exception message) per cycle to the FE queue.
- Supports flush on redirect; flags the last instruction of each packet so the PC generator can retire metadata.

Parameters:
els_p, 4, packet entries (power of 2, >=2)
fetch_insns_p, 2, max instructions per packet (>=1)
instr_width_p, 32, instruction width
vaddr_width_p, 39, virtual PC width
meta_width_p, 64, branch metadata forward width
cnt_width_lp, $clog2(fetch_insns_p+1), local: instruction count width

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  discard all buffered and in-flight state
fetch_v_i  in  1  packet valid
fetch_ready_and_o  out  1  buffer can accept packet
fetch_pc_i  in  vaddr_width_p  PC of instruction 0
fetch_instr_i  in  fetch_insns_p*instr_width_p  instructions, slot 0 in LSBs
fetch_count_i  in  cnt_width_lp  valid instructions, slots 0..count-1
fetch_exc_i  in  2  0 none, 1 itlb miss, 2 page fault, 3 access fault
fetch_meta_i  in  meta_width_p  branch metadata for packet
fe_v_o  out  1  output valid
fe_ready_and_i  in  1  FE queue ready
fe_pc_o  out  vaddr_width_p  PC of emitted item
fe_instr_o  out  instr_width_p  instruction (0 for exception)
fe_exc_o  out  2  exception code of emitted item
fe_meta_o  out  meta_width_p  packet metadata
fe_last_o  out  1  last item of its packet
count_o  out  $clog2(els_p+1)  occupied packet entries

Behaviour:
- Clock clk_i; reset_i synchronous, active-high.
- Reset: all entries invalid, head/tail pointers 0, slot index 0.
  - Outputs after reset: fe_v_o=0, count_o=0, fetch_ready_and_o=1, fe_pc_o/fe_instr_o/fe_exc_o/fe_meta_o/fe_last_o=0.
- Storage: circular array of els_p packets.
  - Pointers are clog2(els_p) bits wide and wrap naturally; a wrap bit distinguishes full from empty.
- Enqueue:
  - Occurs on fetch_v_i & fetch_ready_and_o.
  - fetch_ready_and_o = !full, registered-state only; it does not depend on same-cycle dequeue.
  - Packet with fetch_exc_i=0 and fetch_count_i=0 is acknowledged but not stored.
  - fetch_count_i > fetch_insns_p is illegal; assert in simulation.
- No bypass: an enqueued packet is first visible at the output on the next cycle.
- Output:
  - fe_v_o = head entry valid.
  - Non-exception head: emit slot idx; fe_pc_o = pc + 4*idx, truncated to vaddr_width_p (wraps mod 2^vaddr_width_p); fe_exc_o=0.
  - Exception head: emit a single item with fe_pc_o=pc, fe_instr_o=0, fe_exc_o=code, fe_last_o=1; stored instructions are ignored.
  - fe_meta_o = head metadata on every item.
  - fe_last_o = exception | (idx == count-1).
- Dequeue:
  - Occurs on fe_v_o & fe_ready_and_i.
  - If not last: idx++.
  - If last: idx=0, head advances, entry freed.
- Simultaneous enqueue and dequeue: both occur, count unchanged.
  - When full, enqueue is refused even if a dequeue happens that cycle.
- Flush:
  - flush_i clears all entries, pointers and idx at the next edge.
  - An enqueue in the same cycle is dropped; flush wins.
  - fetch_ready_and_o stays driven by pre-flush state.
  - fe_v_o may be high during the flush cycle; a handshake in that cycle is legal and is consumed.
- reset_i overrides flush_i and everything else.
- count_o reflects registered occupancy; a partially drained head counts as 1.

Test Plan:
- Reset, then push pc=0x1000, count=2, instr={B,A} -> next cycle fe_v_o=1, pc 0x1000/A last=0, then 0x1004/B last=1; count_o returns to 0.
- Fill 4 packets with fe_ready_and_i=0 -> count_o=4, fetch_ready_and_o=0. Assert ready plus a push in the same cycle -> push refused. Drain -> items in FIFO order; pointers wrap correctly on refill.
- Push exc=1 at pc=0x2000 with count=2 -> exactly one item: exc=1, instr=0, last=1, pc=0x2000.
- Push count=0 exc=0 -> acknowledged; fe_v_o stays 0; count_o stays 0.
- Mid-drain (idx=1 of 2) assert flush_i with a concurrent push -> next cycle fe_v_o=0, count_o=0. Next push starts at its own slot 0.
- pc = 2^39-4, count=2 -> second item pc=0 (wrap). Then reset_i asserted together with flush_i and push -> all reset values.
